// File: rtl/qlearn_pkg.sv
// Shared types and constants for the epsilon-greedy Q-learning action selector.
package qlearn_pkg;

  localparam int NUM_ACTIONS   = 4;
  localparam int Q_WIDTH       = 32;
  localparam int ACTIONS_WIDTH = $clog2(NUM_ACTIONS);

  // Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/qlearn_action_sel_if.sv
// Request/response bundle between the Q-learning core and the action selector.
interface qlearn_action_sel_if #(
  parameter int NUM_ACTIONS   = 4,
  parameter int Q_WIDTH       = 32,
  parameter int ACTIONS_WIDTH = $clog2(NUM_ACTIONS)
);
  logic                           i_req;
  logic [NUM_ACTIONS*Q_WIDTH-1:0] i_q_values;
  logic [7:0]                     i_epsilon;
  logic [ACTIONS_WIDTH-1:0]       o_action;
  logic                           o_explore;
  logic                           o_valid;

  modport master (
    output i_req, i_q_values, i_epsilon,
    input  o_action, o_explore, o_valid
  );

  modport slave (
    input  i_req, i_q_values, i_epsilon,
    output o_action, o_explore, o_valid
  );
endinterface

// File: rtl/qlearn_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced so the register never locks up.
module qlearn_lfsr16
  import qlearn_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] o_rand
);

  logic [15:0] seed_eff_s;

  // Substitute the all-zero lock-up seed
  always_comb begin
    seed_eff_s = seed;
    if (seed == 16'h0000) begin
      seed_eff_s = 16'h0001;
    end else begin
      seed_eff_s = seed;
    end
  end

  // Advance every clock independent of selector state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rand <= seed_eff_s;
    end else begin
      o_rand <= lfsr_next(o_rand);
    end
  end

endmodule

// File: rtl/qlearn_action_sel.sv
// Epsilon-greedy action selector: sequential argmax over a captured Q-row,
// overridden by an LFSR-chosen action when the exploration draw wins.
module qlearn_action_sel
  import qlearn_pkg::*;
#(
  parameter int          NUM_ACTIONS = 4,
  parameter int          Q_WIDTH     = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                clk,
  input logic                rst_n,
  qlearn_action_sel_if.slave bus
);

  localparam int ACT_W = $clog2(NUM_ACTIONS);

  state_e                         state_r, state_nxt_s;
  logic [ACT_W-1:0]               idx_r, idx_nxt_s;
  logic signed [Q_WIDTH-1:0]      best_r, best_nxt_s;
  logic [ACT_W-1:0]               best_idx_r, best_idx_nxt_s;
  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_cap_r, q_cap_nxt_s;
  logic [7:0]                     eps_cap_r, eps_cap_nxt_s;
  logic [15:0]                    lfsr_cap_r, lfsr_cap_nxt_s;
  logic [ACT_W-1:0]               action_r, action_nxt_s;
  logic                           explore_r, explore_nxt_s;
  logic                           valid_r, valid_nxt_s;
  logic [15:0]                    rand_s;
  logic signed [Q_WIDTH-1:0]      cand_s;
  logic                           explore_s;
  logic [ACT_W-1:0]               explore_act_s;

  qlearn_lfsr16 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .seed   (LFSR_SEED),
    .o_rand (rand_s)
  );

  assign cand_s        = $signed(q_cap_r[idx_r*Q_WIDTH +: Q_WIDTH]);
  // eps=FF forces exploration so the full byte range is reachable
  assign explore_s     = (eps_cap_r == 8'hFF) || (lfsr_cap_r[7:0] < eps_cap_r);
  assign explore_act_s = ACT_W'(lfsr_cap_r[15:8] % 8'(NUM_ACTIONS));

  // Next-state and datapath update for IDLE -> SCAN -> DONE
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    best_nxt_s     = best_r;
    best_idx_nxt_s = best_idx_r;
    q_cap_nxt_s    = q_cap_r;
    eps_cap_nxt_s  = eps_cap_r;
    lfsr_cap_nxt_s = lfsr_cap_r;
    action_nxt_s   = action_r;
    explore_nxt_s  = explore_r;
    valid_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_req) begin
          q_cap_nxt_s    = bus.i_q_values;
          eps_cap_nxt_s  = bus.i_epsilon;
          lfsr_cap_nxt_s = rand_s;
          best_nxt_s     = $signed(bus.i_q_values[Q_WIDTH-1:0]);
          best_idx_nxt_s = ACT_W'(0);
          idx_nxt_s      = ACT_W'(1);
          state_nxt_s    = ST_SCAN;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // Strict compare keeps the lowest index on ties
        if (cand_s > best_r) begin
          best_nxt_s     = cand_s;
          best_idx_nxt_s = idx_r;
        end else begin
          best_nxt_s     = best_r;
          best_idx_nxt_s = best_idx_r;
        end
        idx_nxt_s = idx_r + ACT_W'(1);
        if (idx_r == ACT_W'(NUM_ACTIONS - 1)) begin
          state_nxt_s = ST_DONE;
          valid_nxt_s = 1'b1;
          if (explore_s) begin
            action_nxt_s  = explore_act_s;
            explore_nxt_s = 1'b1;
          end else begin
            action_nxt_s  = best_idx_nxt_s;
            explore_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scan datapath, captured operands and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r      <= '0;
      best_r     <= '0;
      best_idx_r <= '0;
      q_cap_r    <= '0;
      eps_cap_r  <= 8'h00;
      lfsr_cap_r <= 16'h0000;
      action_r   <= '0;
      explore_r  <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      idx_r      <= idx_nxt_s;
      best_r     <= best_nxt_s;
      best_idx_r <= best_idx_nxt_s;
      q_cap_r    <= q_cap_nxt_s;
      eps_cap_r  <= eps_cap_nxt_s;
      lfsr_cap_r <= lfsr_cap_nxt_s;
      action_r   <= action_nxt_s;
      explore_r  <= explore_nxt_s;
      valid_r    <= valid_nxt_s;
    end
  end

  assign bus.o_action  = action_r;
  assign bus.o_explore = explore_r;
  assign bus.o_valid   = valid_r;

endmodule

// File: tb/tb_qlearn_action_sel.sv
// Scoreboard bench for qlearn_action_sel: reference LFSR + argmax model, latency tracking.
module tb_qlearn_action_sel;

  localparam int NA = 4;
  localparam int QW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qlearn_action_sel_if #(.NUM_ACTIONS(NA), .Q_WIDTH(QW)) bus ();

  qlearn_action_sel #(.NUM_ACTIONS(NA), .Q_WIDTH(QW), .LFSR_SEED(16'hACE1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] act;
    logic       expl;
    int         due;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          valid_cnt = 0;
  int          explore_cnt = 0;
  logic [3:0]  seen_mask = 4'h0;
  logic [15:0] lfsr_m;

  function automatic logic [15:0] ref_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  // Reference LFSR tracking the DUT generator from reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= ref_next(lfsr_m);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every strobe must match the oldest prediction
  always @(negedge clk) begin : mon_blk
    exp_t e;
    if (rst_n && bus.o_valid) begin
      valid_cnt++;
      if (bus.o_explore) begin
        explore_cnt++;
        seen_mask[bus.o_action] = 1'b1;
      end
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("action", 32'(bus.o_action), 32'(e.act));
        check("explore", 32'(bus.o_explore), 32'(e.expl));
        check("latency", cyc, e.due);
      end
    end
  end

  // Predict the decision for a request accepted at the coming rising edge
  task automatic predict(input logic [127:0] q, input logic [7:0] eps);
    exp_t        e;
    int signed   best;
    int signed   v;
    logic [1:0]  bi;
    best = $signed(q[31:0]);
    bi   = 2'd0;
    for (int k = 1; k < NA; k++) begin
      v = $signed(q[k*QW +: QW]);
      if (v > best) begin
        best = v;
        bi   = 2'(k);
      end
    end
    if (eps == 8'hFF || lfsr_m[7:0] < eps) begin
      e.act  = 2'(lfsr_m[15:8] % 8'd4);
      e.expl = 1'b1;
    end else begin
      e.act  = bi;
      e.expl = 1'b0;
    end
    e.due = cyc + 4;
    sb_q.push_back(e);
  endtask

  // Single request from an idle DUT; inputs are scrambled after acceptance
  task automatic do_req(input logic [127:0] q, input logic [7:0] eps);
    bus.i_q_values = q;
    bus.i_epsilon  = eps;
    bus.i_req      = 1'b1;
    predict(q, eps);
    @(posedge clk);
    #1;
    bus.i_req      = 1'b0;
    bus.i_q_values = {$urandom, $urandom, $urandom, $urandom};
    bus.i_epsilon  = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int busy;
    logic [127:0] qb;
    rst_n          = 1'b0;
    bus.i_req      = 1'b0;
    bus.i_q_values = '0;
    bus.i_epsilon  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_action", 32'(bus.o_action), 32'd0);
    check("rst_explore", 32'(bus.o_explore), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Greedy with tie, then signed compare
    do_req(pack4(5, -3, 9, 9), 8'd0);
    wait_done();
    check("tie_hold", 32'(bus.o_action), 32'd2);
    do_req(pack4(-7, -2, -100, -2), 8'd0);
    wait_done();
    check("signed_hold", 32'(bus.o_action), 32'd1);
    check("signed_explore", 32'(bus.o_explore), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_req({$urandom, $urandom, $urandom, $urandom}, 8'd0);
      wait_done();
    end

    // Forced exploration
    for (int i = 0; i < 16; i++) begin
      do_req({$urandom, $urandom, $urandom, $urandom}, 8'hFF);
      wait_done();
    end

    // Continuous request: only every fifth edge is accepted
    v0 = valid_cnt;
    busy = 0;
    qb = pack4(1, 2, 3, 0);
    bus.i_q_values = qb;
    bus.i_epsilon  = 8'd0;
    for (int i = 0; i < 20; i++) begin
      if (busy == 0) begin
        predict(qb, 8'd0);
        busy = 4;
      end else begin
        busy--;
      end
      bus.i_req = 1'b1;
      @(negedge clk);
    end
    bus.i_req = 1'b0;
    wait_done();
    check("busy_pulses", 32'(valid_cnt - v0), 32'd4);

    // Reset in the middle of a scan
    do_req(pack4(0, 0, 7, 0), 8'd0);
    wait_done();
    do_req(pack4(9, 0, 0, 0), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("abort_valid", 32'(bus.o_valid), 32'd0);
    check("abort_action", 32'(bus.o_action), 32'd0);
    check("abort_explore", 32'(bus.o_explore), 32'd0);
    v0 = valid_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(pack4(1, 4, 2, 3), 8'd0);
    wait_done();
    repeat (6) @(negedge clk);
    check("abort_no_strobe", 32'(valid_cnt - v0), 32'd1);

    // Exploration statistics at eps=128
    explore_cnt = 0;
    seen_mask   = 4'h0;
    for (int i = 0; i < 1024; i++) begin
      do_req({$urandom, $urandom, $urandom, $urandom}, 8'd128);
      wait_done();
    end
    check("explore_range", 32'(explore_cnt >= 448 && explore_cnt <= 576), 32'd1);
    check("explore_cover", 32'(seen_mask), 32'hF);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
